mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MIPS MEM pipeline stage. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Drives a variable-latency data-memory port with a req/ack handshake.
- Resolves branches as PCSrc = Branch & Zero.
- Generates a pipeline stall while a memory access is outstanding, inserts a WB bubble, and flags misaligned accesses, overflow and bus timeouts.

Parameters:
- TIMEOUT, 16: maximum cycles a request may wait for ack before it is aborted as a bus error. Legal range 2..255.
- CNT_W, 8: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  asynchronous active-low reset
- i_MEM_data_ALUOut  in  32  effective address / ALU result
- i_MEM_data_RTData  in  32  store data
- i_MEM_data_PCBranch  in  32  branch target
- i_MEM_data_Zero  in  1  ALU zero flag
- i_MEM_data_Overflow  in  1  ALU overflow flag
- i_MEM_ctrl_MemRead  in  1  load
- i_MEM_ctrl_MemWrite  in  1  store
- i_MEM_ctrl_Branch  in  1  branch instruction
- i_WB_ctrl_Mem2Reg  in  1  WB source select
- i_WB_ctrl_RegWrite  in  1  WB write enable
- i_WB_data_RegAddrW  in  5  WB destination register
- o_dmem_req  out  1  memory request
- o_dmem_we  out  1  1 = write
- o_dmem_addr  out  32  word address, byte-addressed with [1:0] = 0
- o_dmem_wdata  out  32  write data
- i_dmem_ack  in  1  request completed this cycle
- i_dmem_rdata  in  32  read data, valid when ack = 1
- o_IF_ctrl_PCSrc  out  1  take branch
- o_IF_data_PCBranch  out  32  branch target, passed through
- o_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle
- o_WB_data_MemData  out  32  load data to MEM/WB
- o_WB_data_ALUOut  out  32  ALU result to MEM/WB
- o_WB_data_RegAddrW  out  5  passed through
- o_WB_ctrl_Mem2Reg  out  1  passed through
- o_WB_ctrl_RegWrite  out  1  gated write enable
- o_exc_AdE  out  1  one-cycle pulse: misaligned load/store
- o_exc_Ov  out  1  one-cycle pulse: overflow
- o_exc_BusErr  out  1  one-cycle pulse: access timed out

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-low, on nrst. FSM goes to IDLE, wait counter to 0, all o_exc_* to 0.
- While nrst = 0, every combinational output is forced to 0 (all outputs are ANDed with nrst).
- Definitions:
  - mem_op = MemRead | MemWrite
  - misalign = (ALUOut[1:0] != 0)
  - go = mem_op & ~misalign & ~Overflow
- FSM states: IDLE, WAIT.
- IDLE:
  - o_dmem_req = go.
  - If go & ack: the access completes this cycle, o_stall = 0, state stays IDLE (zero-wait memory).
  - If go & ~ack: o_stall = 1, go to WAIT, counter <= 1.
- WAIT:
  - o_dmem_req = 1; address, we and wdata are taken from the held EX/MEM inputs.
  - If ack: o_stall = 0, go to IDLE, counter <= 0.
  - Else if counter == TIMEOUT-1: abort. o_stall = 0 this cycle, o_exc_BusErr = 1 next cycle, go to IDLE.
  - Else: o_stall = 1, counter increments.
- o_dmem_we = MemWrite. o_dmem_addr = ALUOut. o_dmem_wdata = RTData.
- Request stability: req, we, addr and wdata do not change while req = 1 and ack = 0. This holds because upstream is held by o_stall.
- o_WB_data_MemData = i_dmem_rdata when a load completes this cycle, else 0.
- o_WB_ctrl_RegWrite = RegWrite & ~Overflow & ~stall & ~(mem_op & misalign) & ~(abort & MemRead).
  - A stalled cycle therefore presents a bubble to MEM/WB.
- o_IF_ctrl_PCSrc = Branch & Zero, never during stall. Branch and mem_op never coexist; if both are set, mem_op takes precedence and PCSrc = 0.
- Exception pulses, each registered and one cycle after the causing cycle:
  - o_exc_AdE = mem_op & misalign.
  - o_exc_Ov = Overflow.
  - No access is issued in either case.
- Ack while req = 0 is ignored.
- Reset asserted in WAIT: req drops immediately, no completion and no exception is reported.
- Timeout boundary: an ack arriving in the same cycle the counter reaches TIMEOUT-1 counts as completion, not abort.
- Back-to-back memory ops: the second request may be asserted in the cycle after the first completes. No dead cycle is inserted.

Decomposition:
- Shared package mips_pkg holds:
  - state encoding MEM_IDLE / MEM_WAIT
  - alignment mask constant 2'b00
  - exception code constants (AdE, Ov, BusErr) used by the future CP0 block
- One sub-module: mem_wait_timer (counter plus timeout compare, parameterised by TIMEOUT and CNT_W). Everything else stays inline.

Test Plan:
- Load, ALUOut = 0x100, ack in the same cycle, rdata = 0xDEADBEEF → req = 1 for one cycle, stall = 0, MemData = 0xDEADBEEF, RegWrite = 1.
- Store, ALUOut = 0x204, RTData = 0x12345678, ack after 3 cycles → req = 1 and we = 1 for 4 cycles, stall = 1 for 3 cycles with RegWrite = 0, stall = 0 on the ack cycle.
- Load, ALUOut = 0x102 → req never asserted, o_exc_AdE pulses one cycle later, RegWrite = 0, stall = 0.
- Load with ack never returned, TIMEOUT = 16 → stall = 1 for 15 cycles, abort on the 16th, o_exc_BusErr pulse next cycle, RegWrite = 0.
- Branch = 1, Zero = 1, PCBranch = 0x40 → PCSrc = 1, target = 0x40. Repeat with Zero = 0 → PCSrc = 0.
- nrst pulled low in WAIT after 2 cycles → req, stall and all outputs go to 0 immediately. After release: state IDLE, no BusErr pulse.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared MEM-stage state encoding, alignment and exception-code constants
package mips_pkg;
    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;
    localparam logic [1:0] WORD_ALIGN = 2'b00;
    localparam logic [4:0] EXC_ADE    = 5'd4;
    localparam logic [4:0] EXC_OV     = 5'd12;
    localparam logic [4:0] EXC_BUSERR = 5'd7;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles an access has waited for ack and flags the last allowed one
// Ports: clk, nrst (async, active-low); start loads 1, run increments, otherwise clears;
// expired is high while the count equals TIMEOUT-1.
module mem_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic nrst,
    input  logic start,
    input  logic run,
    output logic expired
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) cnt <= '0;
        else       cnt <= start ? CNT_W'(1) : run ? cnt + CNT_W'(1) : '0;
    end
    assign expired = cnt == CNT_W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage with req/ack data-memory port, branch resolve, stall and exceptions
// Ports: EX/MEM inputs (i_MEM_*, i_WB_*), data-memory port (o_dmem_*, i_dmem_*),
// branch outputs to IF (o_IF_*), o_stall to upstream, MEM/WB outputs (o_WB_*),
// registered one-cycle exception pulses (o_exc_*).
module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] i_MEM_data_ALUOut,
    input  logic [31:0] i_MEM_data_RTData,
    input  logic [31:0] i_MEM_data_PCBranch,
    input  logic        i_MEM_data_Zero,
    input  logic        i_MEM_data_Overflow,
    input  logic        i_MEM_ctrl_MemRead,
    input  logic        i_MEM_ctrl_MemWrite,
    input  logic        i_MEM_ctrl_Branch,
    input  logic        i_WB_ctrl_Mem2Reg,
    input  logic        i_WB_ctrl_RegWrite,
    input  logic [4:0]  i_WB_data_RegAddrW,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_IF_ctrl_PCSrc,
    output logic [31:0] o_IF_data_PCBranch,
    output logic        o_stall,
    output logic [31:0] o_WB_data_MemData,
    output logic [31:0] o_WB_data_ALUOut,
    output logic [4:0]  o_WB_data_RegAddrW,
    output logic        o_WB_ctrl_Mem2Reg,
    output logic        o_WB_ctrl_RegWrite,
    output logic        o_exc_AdE,
    output logic        o_exc_Ov,
    output logic        o_exc_BusErr
);
    mem_state_t state;
    logic mem_op, misalign, go, in_wait, expired, abort, done;
    assign mem_op   = i_MEM_ctrl_MemRead | i_MEM_ctrl_MemWrite;
    assign misalign = i_MEM_data_ALUOut[1:0] != WORD_ALIGN;
    assign go       = mem_op & ~misalign & ~i_MEM_data_Overflow;
    assign in_wait  = state == MEM_WAIT;
    // An ack on the last allowed cycle wins over the abort.
    assign abort    = in_wait & ~i_dmem_ack & expired;
    assign done     = o_dmem_req & i_dmem_ack;

    mem_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .nrst    (nrst),
        .start   (~in_wait & go & ~i_dmem_ack),
        .run     (in_wait & ~i_dmem_ack & ~expired),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= MEM_IDLE;
            o_exc_AdE    <= 1'b0;
            o_exc_Ov     <= 1'b0;
            o_exc_BusErr <= 1'b0;
        end else begin
            state        <= in_wait ? ((i_dmem_ack | expired) ? MEM_IDLE : MEM_WAIT)
                                    : ((go & ~i_dmem_ack) ? MEM_WAIT : MEM_IDLE);
            o_exc_AdE    <= mem_op & misalign;
            o_exc_Ov     <= i_MEM_data_Overflow;
            o_exc_BusErr <= abort;
        end
    end

    // Upstream holds the EX/MEM register while stalled, so the request stays stable in WAIT.
    assign o_dmem_req         = nrst & (in_wait | go);
    assign o_dmem_we          = nrst & i_MEM_ctrl_MemWrite;
    assign o_dmem_addr        = nrst ? i_MEM_data_ALUOut : '0;
    assign o_dmem_wdata       = nrst ? i_MEM_data_RTData : '0;
    assign o_stall            = o_dmem_req & ~i_dmem_ack & ~abort;
    assign o_IF_ctrl_PCSrc    = nrst & i_MEM_ctrl_Branch & i_MEM_data_Zero & ~mem_op & ~o_stall;
    assign o_IF_data_PCBranch = nrst ? i_MEM_data_PCBranch : '0;
    assign o_WB_data_MemData  = (done & i_MEM_ctrl_MemRead) ? i_dmem_rdata : '0;
    assign o_WB_data_ALUOut   = nrst ? i_MEM_data_ALUOut : '0;
    assign o_WB_data_RegAddrW = nrst ? i_WB_data_RegAddrW : '0;
    assign o_WB_ctrl_Mem2Reg  = nrst & i_WB_ctrl_Mem2Reg;
    // A stalled cycle presents a bubble to MEM/WB.
    assign o_WB_ctrl_RegWrite = nrst & i_WB_ctrl_RegWrite & ~i_MEM_data_Overflow & ~o_stall
                                & ~(mem_op & misalign) & ~(abort & i_MEM_ctrl_MemRead);
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage
module tb_mem_stage;
    logic        clk = 1'b0, nrst = 1'b0;
    logic [31:0] alu = '0, rt = '0, pcb = '0, rdata = '0;
    logic        zero = 1'b0, ov = 1'b0, mr = 1'b0, mw = 1'b0, br = 1'b0;
    logic        m2r = 1'b0, rw = 1'b0, ack = 1'b0;
    logic [4:0]  ra = '0;
    logic        req, we, pcsrc, stall, m2r_o, rw_o, ade, ovx, berr;
    logic [31:0] addr, wdata, pcb_o, md, alu_o;
    logic [4:0]  ra_o;
    int          n_run = 0, n_fail = 0;

    typedef struct {
        logic req, we, stall, rw, pcsrc, ade, ov, berr;
        logic [31:0] md, addr, wdata, pcb;
    } exp_t;
    exp_t q[$];

    mem_stage dut (
        .clk(clk), .nrst(nrst),
        .i_MEM_data_ALUOut(alu), .i_MEM_data_RTData(rt), .i_MEM_data_PCBranch(pcb),
        .i_MEM_data_Zero(zero), .i_MEM_data_Overflow(ov),
        .i_MEM_ctrl_MemRead(mr), .i_MEM_ctrl_MemWrite(mw), .i_MEM_ctrl_Branch(br),
        .i_WB_ctrl_Mem2Reg(m2r), .i_WB_ctrl_RegWrite(rw), .i_WB_data_RegAddrW(ra),
        .o_dmem_req(req), .o_dmem_we(we), .o_dmem_addr(addr), .o_dmem_wdata(wdata),
        .i_dmem_ack(ack), .i_dmem_rdata(rdata),
        .o_IF_ctrl_PCSrc(pcsrc), .o_IF_data_PCBranch(pcb_o), .o_stall(stall),
        .o_WB_data_MemData(md), .o_WB_data_ALUOut(alu_o), .o_WB_data_RegAddrW(ra_o),
        .o_WB_ctrl_Mem2Reg(m2r_o), .o_WB_ctrl_RegWrite(rw_o),
        .o_exc_AdE(ade), .o_exc_Ov(ovx), .o_exc_BusErr(berr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("req", 32'(req), 32'(e.req));
            chk("we", 32'(we), 32'(e.we));
            chk("stall", 32'(stall), 32'(e.stall));
            chk("regwrite", 32'(rw_o), 32'(e.rw));
            chk("pcsrc", 32'(pcsrc), 32'(e.pcsrc));
            chk("memdata", md, e.md);
            chk("addr", addr, e.addr);
            chk("wdata", wdata, e.wdata);
            chk("pcbranch", pcb_o, e.pcb);
            chk("exc_ade", 32'(ade), 32'(e.ade));
            chk("exc_ov", 32'(ovx), 32'(e.ov));
            chk("exc_buserr", 32'(berr), 32'(e.berr));
        end
    end

    // Expected outputs for the cycle just driven; pass-through fields follow the driven inputs.
    task automatic drive(input logic e_req, e_stall, e_rw, e_pc, input logic [31:0] e_md,
                         input logic e_ade, e_ov, e_be);
        exp_t e;
        e.req = e_req; e.stall = e_stall; e.rw = e_rw; e.pcsrc = e_pc; e.md = e_md;
        e.ade = e_ade; e.ov = e_ov; e.berr = e_be;
        e.we    = nrst & mw;
        e.addr  = nrst ? alu : 32'h0;
        e.wdata = nrst ? rt : 32'h0;
        e.pcb   = nrst ? pcb : 32'h0;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic r, w, b, z, o, wr, a, input logic [31:0] al, d, pc, rd);
        mr = r; mw = w; br = b; zero = z; ov = o; rw = wr; ack = a;
        alu = al; rt = d; pcb = pc; rdata = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        // reset: everything forced low even with an acked load presented
        set(1, 0, 0, 0, 0, 1, 1, 32'h100, 32'h0, 32'h40, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        nrst = 1'b1;
        set(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // zero-wait load
        set(1, 0, 0, 0, 0, 1, 1, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF);
        drive(1, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0);
        // store acked after 3 wait cycles, then back-to-back load
        set(0, 1, 0, 0, 0, 0, 0, 32'h204, 32'h12345678, 32'h0, 32'hBAD0BAD0);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0, 0, 0, 0);
        ack = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        set(1, 0, 0, 0, 0, 1, 1, 32'h108, 32'h0, 32'h0, 32'hCAFEF00D);
        drive(1, 0, 1, 0, 32'hCAFEF00D, 0, 0, 0);
        // misaligned load
        set(1, 0, 0, 0, 0, 1, 1, 32'h102, 32'h0, 32'h0, 32'hBAD0BAD0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        set(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        // overflow on an ALU op, and on a load (no access issued)
        set(0, 0, 0, 0, 1, 1, 0, 32'h7, 32'h0, 32'h0, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        set(1, 0, 0, 0, 1, 1, 1, 32'h10, 32'h0, 32'h0, 32'hBAD0BAD0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        set(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        // load that never gets an ack: 15 stall cycles, abort on the 16th
        set(1, 0, 0, 0, 0, 1, 0, 32'h300, 32'h0, 32'h0, 32'hBAD0BAD0);
        for (int i = 0; i < 15; i++) drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        set(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // ack on the last allowed cycle is a completion
        set(1, 0, 0, 0, 0, 1, 0, 32'h400, 32'h0, 32'h0, 32'h0BADF00D);
        for (int i = 0; i < 15; i++) drive(1, 1, 0, 0, 0, 0, 0, 0);
        ack = 1'b1;
        drive(1, 0, 1, 0, 32'h0BADF00D, 0, 0, 0);
        set(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // branches, and branch+mem_op conflict
        set(0, 0, 1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h40, 32'h0);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        zero = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        set(1, 0, 1, 1, 0, 1, 1, 32'h80, 32'h0, 32'h44, 32'h55AA55AA);
        drive(1, 0, 1, 0, 32'h55AA55AA, 0, 0, 0);
        // ack without a request is ignored
        set(0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0, 32'h77777777);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        // reset while waiting: outputs drop at once, no BusErr afterwards
        set(1, 0, 0, 0, 0, 1, 0, 32'h500, 32'h0, 32'h0, 32'h0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        nrst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        nrst = 1'b1;
        set(0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0, 32'h0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        // fresh zero-wait load proves the FSM came back in IDLE
        set(1, 0, 0, 0, 0, 1, 1, 32'h600, 32'h0, 32'h0, 32'h13579BDF);
        drive(1, 0, 1, 0, 32'h13579BDF, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
